// File: rtl/dmem_arbiter.sv
// dmem_arbiter
// Shares the single-port data memory between the CPU load/store port and a
// debug port. Accesses are serialised through IDLE -> ACCESS -> WAIT -> RESP.
// The CPU has fixed priority, but the debug port is granted once the CPU has
// won STARVE_MAX consecutive contested arbitrations.
//
// Ports
//   clk, rst_n                      clock, synchronous active-low reset
//   cpu_req/we/addr/wdata           CPU request, held stable until cpu_ack
//   cpu_rdata, cpu_ack, cpu_stall   CPU read data, completion pulse, stall
//   dbg_req/we/addr/wdata           debug request, held stable until dbg_ack
//   dbg_rdata, dbg_ack              debug read data, completion pulse
//   mem_en/we/addr/wdata            memory strobe and write controls
//   mem_rdata                       memory read data, valid MEM_LAT cycles
//                                   after the mem_en cycle
//
// state  | meaning
// IDLE   | arbitrate, latch the winner's request
// ACCESS | drive mem_en for one cycle, load latency counter
// WAIT   | count down memory latency, capture read data at count 1
// RESP   | one-cycle ack to the owner, requests ignored
module dmem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ack,
  output logic              cpu_stall,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              dbg_ack,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int SW = ($clog2(STARVE_MAX + 1) > 3) ? $clog2(STARVE_MAX + 1) : 3;
  localparam logic [SW-1:0] STREAK_MAX = SW'(STARVE_MAX);
  localparam logic [3:0]    LAT_LOAD   = 4'(MEM_LAT);

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;

  state_t            state, state_nxt;
  logic [3:0]        lat_cnt;
  logic [SW-1:0]     streak;
  logic              owner_dbg;
  logic              lat_we;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic              grant;
  logic              grant_dbg;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    grant_dbg = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    cpu_ack   = 1'b0;
    dbg_ack   = 1'b0;
    case (state)
      IDLE: begin
        if (cpu_req || dbg_req) begin
          grant     = 1'b1;
          // Debug wins when alone, or when the CPU streak has hit its limit.
          grant_dbg = dbg_req & (~cpu_req | (streak == STREAK_MAX));
          state_nxt = ACCESS;
        end
      end
      ACCESS: begin
        mem_en    = 1'b1;
        mem_we    = lat_we;
        state_nxt = WAIT;
      end
      WAIT: begin
        if (lat_cnt == 4'd1) state_nxt = RESP;
      end
      RESP: begin
        cpu_ack   = ~owner_dbg;
        dbg_ack   = owner_dbg;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      owner_dbg <= 1'b0;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_cnt   <= '0;
      streak    <= '0;
      cpu_rdata <= '0;
      dbg_rdata <= '0;
    end else begin
      if (grant) begin
        owner_dbg <= grant_dbg;
        lat_we    <= grant_dbg ? dbg_we    : cpu_we;
        lat_addr  <= grant_dbg ? dbg_addr  : cpu_addr;
        lat_wdata <= grant_dbg ? dbg_wdata : cpu_wdata;
      end
      // In IDLE with dbg_req high a grant always happens, so a non-debug
      // grant here is a contested CPU win.
      if (state == IDLE) begin
        if (!dbg_req || grant_dbg) streak <= '0;
        else if (streak != '1)     streak <= streak + SW'(1);
      end
      if (state == ACCESS)    lat_cnt <= LAT_LOAD;
      else if (state == WAIT) lat_cnt <= lat_cnt - 4'd1;
      if (state == WAIT && lat_cnt == 4'd1 && !lat_we) begin
        if (owner_dbg) dbg_rdata <= mem_rdata;
        else           cpu_rdata <= mem_rdata;
      end
    end
  end

  assign mem_addr  = lat_addr;
  assign mem_wdata = lat_wdata;
  assign cpu_stall = cpu_req & ~cpu_ack;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Testbench for dmem_arbiter: behavioural memory with fixed read latency,
// directed transactions, and a scoreboard queue drained by an ack monitor.
module tb_dmem_arbiter;
  localparam int LAT  = 2;
  localparam int SMAX = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_req, cpu_we, dbg_req, dbg_we;
  logic [31:0] cpu_addr, cpu_wdata, dbg_addr, dbg_wdata;
  logic [31:0] cpu_rdata, dbg_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        cpu_ack, cpu_stall, dbg_ack, mem_en, mem_we;

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .cpu_stall(cpu_stall),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_rdata(dbg_rdata), .dbg_ack(dbg_ack),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Memory model: read data appears exactly LAT cycles after mem_en,
  // otherwise a poison value so mistimed captures are visible.
  logic [31:0] mem [0:255];
  logic [31:0] rd_pipe [LAT];
  logic        vd_pipe [LAT];
  always @(posedge clk) begin
    if (mem_en && mem_we) mem[mem_addr[7:0]] <= mem_wdata;
    rd_pipe[0] <= mem[mem_addr[7:0]];
    vd_pipe[0] <= mem_en && !mem_we;
    for (int i = 1; i < LAT; i++) begin
      rd_pipe[i] <= rd_pipe[i-1];
      vd_pipe[i] <= vd_pipe[i-1];
    end
  end
  assign mem_rdata = vd_pipe[LAT-1] ? rd_pipe[LAT-1] : 32'hBAD0_BAD0;

  typedef struct {
    bit          dbg;
    logic [31:0] rdata;
    int          cyc;
  } exp_t;
  exp_t exp_q[$];
  exp_t mon_e;

  always @(negedge clk) begin
    if (cpu_ack || dbg_ack) begin
      chk("dual_ack", 32'(cpu_ack & dbg_ack), 32'd0);
      if (exp_q.size() == 0) begin
        chk("unexpected_ack", 32'(dbg_ack), 32'(cpu_ack));
        chk("unexpected_ack_any", 32'd1, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("ack_port", 32'(dbg_ack), 32'(mon_e.dbg));
        chk("ack_cycle", 32'(cyc), 32'(mon_e.cyc));
        if (mon_e.dbg) chk("dbg_rdata", dbg_rdata, mon_e.rdata);
        else           chk("cpu_rdata", cpu_rdata, mon_e.rdata);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_txn(input bit dbg, input bit we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] exp_rd);
    int t0;
    t0 = cyc;
    if (dbg) begin
      dbg_req = 1'b1; dbg_we = we; dbg_addr = addr; dbg_wdata = wdata;
    end else begin
      cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
    end
    exp_q.push_back('{dbg, exp_rd, t0 + LAT + 2});
    for (int k = 0; k <= LAT + 2; k++) begin
      @(negedge clk);
      chk("mem_en_timing", 32'(mem_en), 32'(k == 1));
      if (k == 1) begin
        chk("mem_we", 32'(mem_we), 32'(we));
        chk("mem_addr", mem_addr, addr);
        if (we) chk("mem_wdata", mem_wdata, wdata);
      end
      chk("ack_timing", 32'(dbg ? dbg_ack : cpu_ack), 32'(k == LAT + 2));
      if (!dbg) chk("cpu_stall", 32'(cpu_stall), 32'(k < LAT + 2));
    end
    tick();
    if (dbg) dbg_req = 1'b0;
    else     cpu_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int r;
    int t0;
    for (int i = 0; i < 256; i++) mem[i] = 32'hA000_0000 + 32'(i);
    mem[8'h10] = 32'hDEAD_BEEF;
    for (int i = 0; i < LAT; i++) begin
      rd_pipe[i] = 32'h0;
      vd_pipe[i] = 1'b0;
    end
    rst_n = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0; cpu_wdata = 32'h0;
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 32'h0; dbg_wdata = 32'h0;

    // Reset with both requests high
    repeat (2) begin
      @(negedge clk);
      chk("rst_mem_en", 32'(mem_en), 32'd0);
      chk("rst_mem_we", 32'(mem_we), 32'd0);
      chk("rst_mem_addr", mem_addr, 32'd0);
      chk("rst_mem_wdata", mem_wdata, 32'd0);
      chk("rst_acks", 32'({cpu_ack, dbg_ack}), 32'd0);
      chk("rst_cpu_rdata", cpu_rdata, 32'd0);
      chk("rst_dbg_rdata", dbg_rdata, 32'd0);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    r = cyc;
    exp_q.push_back('{1'b0, 32'hA000_0000, r + LAT + 2});
    @(negedge clk);
    chk("first_idle_no_en", 32'(mem_en), 32'd0);
    tick();
    dbg_req = 1'b0;
    @(negedge clk);
    chk("first_mem_en", 32'(mem_en), 32'd1);
    repeat (4) tick();
    cpu_req = 1'b0;
    tick();

    // CPU read of 0x10
    do_txn(1'b0, 1'b0, 32'h10, 32'h0, 32'hDEAD_BEEF);
    tick();

    // Debug write 0x20, then CPU read of it
    do_txn(1'b1, 1'b1, 32'h20, 32'h1234_5678, 32'h0);
    do_txn(1'b0, 1'b0, 32'h20, 32'h0, 32'h1234_5678);
    chk("dbg_rdata_untouched", dbg_rdata, 32'h0);
    tick();

    // CPU write with request dropped after grant
    t0 = cyc;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h30; cpu_wdata = 32'h5;
    exp_q.push_back('{1'b0, 32'h1234_5678, t0 + LAT + 2});
    tick();
    tick();
    cpu_req = 1'b0; cpu_we = 1'b0;
    tick();
    tick();
    @(negedge clk);
    chk("drop_cpu_ack", 32'(cpu_ack), 32'd1);
    tick();
    chk("drop_mem_write", mem[8'h30], 32'h5);
    tick();

    // Both requests held continuously
    t0 = cyc;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h40;
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 32'h50;
    for (int i = 0; i < 10; i++) begin
      if (i == 4 || i == 9) exp_q.push_back('{1'b1, 32'hA000_0050, t0 + 4 + 5 * i});
      else                  exp_q.push_back('{1'b0, 32'hA000_0040, t0 + 4 + 5 * i});
    end
    repeat (50) tick();
    cpu_req = 1'b0;
    dbg_req = 1'b0;
    tick();
    chk("arb_all_acked", 32'(exp_q.size()), 32'd0);

    // Reset during WAIT of a debug read
    t0 = cyc;
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 32'h60;
    tick();
    tick();
    rst_n = 1'b0;
    dbg_req = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("midrst_dbg_ack", 32'(dbg_ack), 32'd0);
      chk("midrst_mem_en", 32'(mem_en), 32'd0);
      chk("midrst_dbg_rdata", dbg_rdata, 32'd0);
      if (k == 0) chk("midrst_cpu_rdata", cpu_rdata, 32'd0);
    end
    tick();
    do_txn(1'b1, 1'b0, 32'h60, 32'h0, 32'hA000_0060);
    repeat (3) tick();
    chk("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter and sequencer for the single-port data memory of the single-cycle CPU. It shares the memory between the CPU load/store port and a debug port used for hardware memory inspection and preload. It serialises accesses, models a fixed memory read latency, and generates the CPU stall. Fixed CPU priority is used, with a bounded-starvation guarantee for the debug port.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- MEM_LAT, 2, cycles from the mem_en cycle to valid mem_rdata; legal range 1..15
- STARVE_MAX, 4, maximum consecutive CPU grants while dbg_req is pending; legal range ≥1
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- cpu_req / cpu_we  in  1 / 1  CPU access request / write enable
- cpu_addr / cpu_wdata  in  ADDR_W / DATA_W  CPU address / write data
- cpu_rdata  out  DATA_W  registered read data
- cpu_ack  out  1  one-cycle completion pulse
- cpu_stall  out  1  stall to PC/pipeline; equals cpu_req & ~cpu_ack (combinational)
- dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_rdata, dbg_ack  same semantics as the CPU port
- mem_en / mem_we  out  1 / 1  memory strobe / write enable
- mem_addr / mem_wdata  out  ADDR_W / DATA_W  memory address / write data
- mem_rdata  in  DATA_W  memory read data, valid MEM_LAT cycles after the mem_en cycle

## Operation
- FSM states: IDLE, ACCESS, WAIT, RESP.
- IDLE:
  - Evaluates requests each cycle.
  - On any request, latches owner, we, addr and wdata, then goes to ACCESS.
- ACCESS (1 cycle):
  - mem_en=1; mem_we, mem_addr and mem_wdata come from the latched values.
  - Loads latency counter with MEM_LAT, then goes to WAIT.
- WAIT:
  - Counter decrements each cycle.
  - In the cycle where the counter equals 1, mem_rdata is valid. It is captured into the owner's rdata register only if the access is a read. Then goes to RESP.
- RESP (1 cycle):
  - Owner's ack=1, then goes to IDLE.
  - Requests are ignored in RESP.
- Arbitration in IDLE:
  - Only cpu_req: grant CPU.
  - Only dbg_req: grant debug.
  - Both: grant CPU, unless streak==STARVE_MAX, in which case grant debug.
- streak (3+ bits, saturating):
  - Increments on a CPU grant while dbg_req=1.
  - Clears on a debug grant, or on any IDLE cycle with dbg_req=0.
- Requesters hold req, we, addr and wdata stable until ack. Inputs are latched at grant, so later changes do not affect the transaction in flight.
- A request dropped after grant still completes: a write is performed, and ack pulses anyway.
- rdata of each port holds its value until that port's next read completes. The other port's traffic and writes do not alter it.
- Outputs outside ACCESS: mem_en=0, mem_we=0. mem_addr and mem_wdata hold their last latched values.
- Reset (any state, including mid-transaction):
  - state=IDLE, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - cpu_ack=0, dbg_ack=0, cpu_rdata=0, dbg_rdata=0, streak=0.
  - The in-flight transaction is abandoned with no ack.

## Timing
- Request high in IDLE cycle t → mem_en in cycle t+1 → mem_rdata sampled end of cycle t+1+MEM_LAT → ack in cycle t+2+MEM_LAT → IDLE in t+3+MEM_LAT.
- Read and write latency are identical: request to ack = MEM_LAT+2 cycles.
- Throughput for a continuously held request is one access per MEM_LAT+3 cycles.
  - With MEM_LAT=2: mem_en in cycles 1, 6, 11, …
- cpu_stall is high in every cycle from cpu_req rise through the cycle before cpu_ack. It is low in the ack cycle so the PC advances at that edge.
- Exactly one ack per transaction. ack is never high for both ports in the same cycle.

## Test plan
- **Reset values:** hold rst_n=0 for 2 cycles with both reqs high. Required: all outputs 0 and no mem_en. Release reset: first mem_en occurs one cycle after the first IDLE cycle.
- **CPU read, MEM_LAT=2:** memory word 0x10 = 0xDEADBEEF; cpu_req at cycle 0 with addr=0x10, we=0. Required: mem_en in cycle 1; cpu_ack in cycle 4; cpu_rdata=0xDEADBEEF; cpu_stall high in cycles 0–3 and low in cycle 4.
- **Debug write then CPU read:** debug write to addr 0x20 with data 0x12345678, then CPU read of 0x20. Required: cpu_rdata=0x12345678; dbg_rdata unchanged (0).
- **Simultaneous requests, both held continuously, STARVE_MAX=4:** required grant order is C,C,C,C,D,C,C,C,C,D; no two acks in the same cycle.
- **Request dropped after grant:** cpu write to addr 0x30 with data 0x5; cpu_req drops in cycle 2. Required: cpu_ack still pulses in cycle 4; memory at 0x30 = 0x5.
- **Reset mid-transaction:** assert rst_n=0 in the WAIT cycle of a debug read. Required: no dbg_ack; dbg_rdata=0; state IDLE. A fresh request after release completes normally.
